// File: rtl/id_exe_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_exe_pipe_reg
// Brief    : ID/EX pipeline register with operand forwarding, destination
//            select and branch compare. Optional stall/flush counters when
//            ID_EXE_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module id_exe_pipe_reg #(
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 5,
    parameter int  EX_W   = 5,
    parameter int  MEM_W  = 5,
    localparam int SH_W   = $clog2(DATA_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [2:0]        cmp_op,
    input  logic [1:0]        reg_dst,
    input  logic [DATA_W-1:0] rdata_a,
    input  logic [DATA_W-1:0] rdata_b,
    input  logic [DATA_W-1:0] mem_fwd,
    input  logic [DATA_W-1:0] wb_fwd,
    input  logic [DATA_W-1:0] imm_ext,
    input  logic [DATA_W-1:0] pc4,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [SH_W-1:0]   shamt,
    input  logic [EX_W-1:0]   ctrl_ex,
    input  logic [MEM_W-1:0]  ctrl_mem,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_pc4,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [REG_AW-1:0] out_wsrc,
    output logic [SH_W-1:0]   out_shamt,
    output logic [EX_W-1:0]   out_ctrl_ex,
    output logic [MEM_W-1:0]  out_ctrl_mem,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data,
    output logic              br_taken
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam logic [REG_AW-1:0] c_LINK_REG = '1;

    localparam logic [2:0] c_CMP_EQ  = 3'd0;
    localparam logic [2:0] c_CMP_NE  = 3'd1;
    localparam logic [2:0] c_CMP_LT  = 3'd2;
    localparam logic [2:0] c_CMP_GE  = 3'd3;
    localparam logic [2:0] c_CMP_LTU = 3'd4;
    localparam logic [2:0] c_CMP_GEU = 3'd5;
    localparam logic [2:0] c_CMP_GTZ = 3'd6;

    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [REG_AW-1:0] w_wsrc;
    logic              w_cmp;
    logic              w_a_zero;

    logic              valid_q,    valid_d;
    logic [DATA_W-1:0] a_q,        a_d;
    logic [DATA_W-1:0] b_q,        b_d;
    logic [DATA_W-1:0] imm_q,      imm_d;
    logic [DATA_W-1:0] pc4_q,      pc4_d;
    logic [REG_AW-1:0] rs_q,       rs_d;
    logic [REG_AW-1:0] rt_q,       rt_d;
    logic [REG_AW-1:0] wsrc_q,     wsrc_d;
    logic [SH_W-1:0]   shamt_q,    shamt_d;
    logic [EX_W-1:0]   ctrl_ex_q,  ctrl_ex_d;
    logic [MEM_W-1:0]  ctrl_mem_q, ctrl_mem_d;

    // MEM forward is the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = fwd_a[0] ? mem_fwd : (fwd_a[1] ? wb_fwd : rdata_a);
        w_fwd_b = fwd_b[0] ? mem_fwd : (fwd_b[1] ? wb_fwd : rdata_b);
    end

    always_comb begin
        case (reg_dst)
            2'b01:   w_wsrc = rd;
            2'b10:   w_wsrc = c_LINK_REG;
            default: w_wsrc = rt;
        endcase
    end

    always_comb begin
        w_a_zero = (w_fwd_a == '0);
        case (cmp_op)
            c_CMP_EQ:  w_cmp = (w_fwd_a == w_fwd_b);
            c_CMP_NE:  w_cmp = (w_fwd_a != w_fwd_b);
            c_CMP_LT:  w_cmp = ($signed(w_fwd_a) <  $signed(w_fwd_b));
            c_CMP_GE:  w_cmp = ($signed(w_fwd_a) >= $signed(w_fwd_b));
            c_CMP_LTU: w_cmp = (w_fwd_a <  w_fwd_b);
            c_CMP_GEU: w_cmp = (w_fwd_a >= w_fwd_b);
            c_CMP_GTZ: w_cmp = !w_fwd_a[DATA_W-1] && !w_a_zero;
            default:   w_cmp = w_fwd_a[DATA_W-1] || w_a_zero;
        endcase
    end

    assign fwd_a_data = w_fwd_a;
    assign fwd_b_data = w_fwd_b;
    assign br_taken   = in_valid & w_cmp;

    // A bubble still carries pc4 so the next stage keeps a sane PC.
    always_comb begin
        valid_d    = valid_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        pc4_d      = pc4_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        wsrc_d     = wsrc_q;
        shamt_d    = shamt_q;
        ctrl_ex_d  = ctrl_ex_q;
        ctrl_mem_d = ctrl_mem_q;
        if (flush) begin
            valid_d    = 1'b0;
            a_d        = '0;
            b_d        = '0;
            imm_d      = '0;
            pc4_d      = pc4;
            rs_d       = '0;
            rt_d       = '0;
            wsrc_d     = '0;
            shamt_d    = '0;
            ctrl_ex_d  = '0;
            ctrl_mem_d = '0;
        end else if (!stall) begin
            valid_d    = in_valid;
            a_d        = w_fwd_a;
            b_d        = w_fwd_b;
            imm_d      = imm_ext;
            pc4_d      = pc4;
            rs_d       = rs;
            rt_d       = rt;
            wsrc_d     = w_wsrc;
            shamt_d    = shamt;
            ctrl_ex_d  = ctrl_ex;
            ctrl_mem_d = ctrl_mem;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            valid_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            pc4_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wsrc_q     <= '0;
            shamt_q    <= '0;
            ctrl_ex_q  <= '0;
            ctrl_mem_q <= '0;
        end else begin
            valid_q    <= valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            pc4_q      <= pc4_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            wsrc_q     <= wsrc_d;
            shamt_q    <= shamt_d;
            ctrl_ex_q  <= ctrl_ex_d;
            ctrl_mem_q <= ctrl_mem_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_a        = a_q;
    assign out_b        = b_q;
    assign out_imm      = imm_q;
    assign out_pc4      = pc4_q;
    assign out_rs       = rs_q;
    assign out_rt       = rt_q;
    assign out_wsrc     = wsrc_q;
    assign out_shamt    = shamt_q;
    assign out_ctrl_ex  = ctrl_ex_q;
    assign out_ctrl_mem = ctrl_mem_q;

`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating: a wrapped counter would misreport long stalls as short.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire
